// File: rtl/forward_update_source.sv
// Write-back end of the hashtable pipeline: buffers bucket updates, drains them
// into the memory write port and publishes the forwarding bundles.
module forward_update_source #(
   parameter int unsigned DATA_WIDTH           = 4,
   parameter int unsigned KEY_WIDTH            = 2,
   parameter int unsigned HASH_ADR_WIDTH       = 2,
   parameter int unsigned SHIFT_HASH_ADR_WIDTH = 2,
   parameter int unsigned BUF_DEPTH            = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clk_en,
   input  logic                            upd_valid_i,
   output logic                            upd_ready_o,
   input  logic [HASH_ADR_WIDTH-1:0]       upd_hash_adr_i,
   input  logic [KEY_WIDTH-1:0]            upd_key_i,
   input  logic [DATA_WIDTH-1:0]           upd_data_i,
   input  logic                            upd_entry_valid_i,
   input  logic [SHIFT_HASH_ADR_WIDTH-1:0] upd_shift_adr_i,
   input  logic                            upd_shift_valid_i,
   input  logic                            nm_upd_i,
   input  logic [SHIFT_HASH_ADR_WIDTH-1:0] nm_adr_i,
   input  logic                            nm_valid_i,
   output logic                            mem_we_o,
   input  logic                            mem_ready_i,
   output logic [HASH_ADR_WIDTH-1:0]       mem_adr_o,
   output logic [KEY_WIDTH-1:0]            mem_key_o,
   output logic [DATA_WIDTH-1:0]           mem_data_o,
   output logic                            mem_valid_o,
   output logic [SHIFT_HASH_ADR_WIDTH-1:0] mem_shift_adr_o,
   output logic                            mem_shift_valid_o,
   output logic [HASH_ADR_WIDTH-1:0]       fwd_hash_adr_o,
   output logic [KEY_WIDTH-1:0]            fwd_key_o,
   output logic [DATA_WIDTH-1:0]           fwd_data_o,
   output logic                            fwd_valid_o,
   output logic [SHIFT_HASH_ADR_WIDTH-1:0] fwd_shift_adr_o,
   output logic                            fwd_shift_valid_o,
   output logic                            fwd_updated_mem_o,
   output logic [SHIFT_HASH_ADR_WIDTH-1:0] fwd_next_mem_adr_o,
   output logic                            fwd_next_mem_valid_o,
   output logic                            fwd_next_mem_updated_o
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [HASH_ADR_WIDTH-1:0]       adr;
      logic [KEY_WIDTH-1:0]            key;
      logic [DATA_WIDTH-1:0]           data;
      logic                            valid;
      logic [SHIFT_HASH_ADR_WIDTH-1:0] shift_adr;
      logic                            shift_valid;
   } entry_t;

   entry_t                          ent_q [BUF_DEPTH];
   entry_t                          ent_d [BUF_DEPTH];
   logic [PTR_W-1:0]                head_q, head_d, tail_q, tail_d, newest;
   logic [CNT_W-1:0]                count_q, count_d;
   entry_t                          fwd_q, fwd_d;
   logic                            fwd_upd_q, fwd_upd_d;
   logic [SHIFT_HASH_ADR_WIDTH-1:0] nm_adr_q, nm_adr_d;
   logic                            nm_valid_q, nm_valid_d;
   logic                            nm_upd_q, nm_upd_d;
   entry_t                          upd_entry, head_entry;
   logic                            accept, fire, coalesce, push;

   assign upd_entry = '{adr: upd_hash_adr_i, key: upd_key_i, data: upd_data_i,
                        valid: upd_entry_valid_i, shift_adr: upd_shift_adr_i,
                        shift_valid: upd_shift_valid_i};
   assign head_entry = ent_q[head_q];
   assign newest     = tail_q - PTR_W'(1);

   assign upd_ready_o = (count_q != CNT_W'(BUF_DEPTH));
   assign mem_we_o    = clk_en & (count_q != '0);
   assign fire        = mem_we_o & mem_ready_i;
   assign accept      = clk_en & upd_valid_i & upd_ready_o;
   // The newest entry may only be rewritten if it is not leaving this very cycle.
   assign coalesce    = accept & (count_q != '0) & (ent_q[newest].adr == upd_hash_adr_i)
                        & ~((count_q == CNT_W'(1)) & fire);
   assign push        = accept & ~coalesce;

   always_comb begin
      ent_d      = ent_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      fwd_d      = fwd_q;
      fwd_upd_d  = fwd_upd_q;
      nm_adr_d   = nm_adr_q;
      nm_valid_d = nm_valid_q;
      nm_upd_d   = nm_upd_q;
      if (clk_en) begin
         if (coalesce) ent_d[newest] = upd_entry;
         if (push) begin
            ent_d[tail_q] = upd_entry;
            tail_d        = tail_q + PTR_W'(1);
         end
         if (fire) head_d = head_q + PTR_W'(1);
         case ({push, fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         fwd_upd_d = fire;
         if (fire) fwd_d = head_entry;
         nm_upd_d = nm_upd_i;
         if (nm_upd_i) begin
            nm_adr_d   = nm_adr_i;
            nm_valid_d = nm_valid_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         fwd_q      <= '0;
         fwd_upd_q  <= 1'b0;
         nm_adr_q   <= '0;
         nm_valid_q <= 1'b0;
         nm_upd_q   <= 1'b0;
      end else begin
         ent_q      <= ent_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         fwd_q      <= fwd_d;
         fwd_upd_q  <= fwd_upd_d;
         nm_adr_q   <= nm_adr_d;
         nm_valid_q <= nm_valid_d;
         nm_upd_q   <= nm_upd_d;
      end
   end

   assign mem_adr_o              = head_entry.adr;
   assign mem_key_o              = head_entry.key;
   assign mem_data_o             = head_entry.data;
   assign mem_valid_o            = head_entry.valid;
   assign mem_shift_adr_o        = head_entry.shift_adr;
   assign mem_shift_valid_o      = head_entry.shift_valid;
   assign fwd_hash_adr_o         = fwd_q.adr;
   assign fwd_key_o              = fwd_q.key;
   assign fwd_data_o             = fwd_q.data;
   assign fwd_valid_o            = fwd_q.valid;
   assign fwd_shift_adr_o        = fwd_q.shift_adr;
   assign fwd_shift_valid_o      = fwd_q.shift_valid;
   assign fwd_updated_mem_o      = fwd_upd_q;
   assign fwd_next_mem_adr_o     = nm_adr_q;
   assign fwd_next_mem_valid_o   = nm_valid_q;
   assign fwd_next_mem_updated_o = nm_upd_q;

endmodule

// File: doc/forward_update_source.md
Name: forward_update_source

Overview:
- Write-back end of the second-chance hashtable pipeline: buffers bucket updates from the final pipeline stage and drains them into the bucket memory write port.
- Produces the forwarding bundle consumed by the read-side forward correction logic:
  - written bucket: hash adr, key, data, valid, shift adr, shift valid, updated flag
  - next-memory shift-valid update: adr, valid, updated flag
- One instance per hashtable memory.

Parameters:
DATA_WIDTH, 4, data field width
KEY_WIDTH, 2, key field width
HASH_ADR_WIDTH, 2, bucket address width of this memory
SHIFT_HASH_ADR_WIDTH, 2, bucket address width of next memory
BUF_DEPTH, 4, write buffer entries; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clk_en  in  1  global pipeline enable; low = all state frozen
upd_valid_i  in  1  update request
upd_ready_o  out  1  buffer can accept
upd_hash_adr_i  in  HASH_ADR_WIDTH  target bucket
upd_key_i  in  KEY_WIDTH  key
upd_data_i  in  DATA_WIDTH  data
upd_entry_valid_i  in  1  bucket occupied bit
upd_shift_adr_i  in  SHIFT_HASH_ADR_WIDTH  shift target in next memory
upd_shift_valid_i  in  1  shift target valid
nm_upd_i  in  1  next-memory valid-bit update strobe
nm_adr_i  in  SHIFT_HASH_ADR_WIDTH  next-memory bucket
nm_valid_i  in  1  new valid bit for that bucket
mem_we_o  out  1  memory write request
mem_ready_i  in  1  memory accepts write
mem_adr_o  out  HASH_ADR_WIDTH  write address
mem_key_o  out  KEY_WIDTH  write key
mem_data_o  out  DATA_WIDTH  write data
mem_valid_o  out  1  write occupied bit
mem_shift_adr_o  out  SHIFT_HASH_ADR_WIDTH  write shift adr
mem_shift_valid_o  out  1  write shift valid
fwd_hash_adr_o  out  HASH_ADR_WIDTH  last written bucket
fwd_key_o  out  KEY_WIDTH  last written key
fwd_data_o  out  DATA_WIDTH  last written data
fwd_valid_o  out  1  last written occupied bit
fwd_shift_adr_o  out  SHIFT_HASH_ADR_WIDTH  last written shift adr
fwd_shift_valid_o  out  1  last written shift valid
fwd_updated_mem_o  out  1  fwd_* bundle is fresh this cycle
fwd_next_mem_adr_o  out  SHIFT_HASH_ADR_WIDTH  last next-memory update adr
fwd_next_mem_valid_o  out  1  last next-memory valid bit
fwd_next_mem_updated_o  out  1  next-memory bundle fresh this cycle

Behaviour:
- Buffer: circular FIFO of BUF_DEPTH entries; head/tail pointers wrap modulo BUF_DEPTH; count is clog2(BUF_DEPTH)+1 bits.
- upd_ready_o = (count != BUF_DEPTH); registered-state only, no combinational path from upd_valid_i or mem_ready_i.
- Accept: clk_en & upd_valid_i & upd_ready_o.
- Drain: mem_we_o = clk_en & (count != 0). mem_* show head entry combinationally. Fire = mem_we_o & mem_ready_i; fire pops head.
- Coalesce:
  - Condition: accepted update with hash adr equal to the newest entry's adr, count >= 1, and that newest entry is not being popped this cycle (i.e. not count==1 & fire).
  - Action: overwrite the newest entry in place; count unchanged.
  - Otherwise the update is pushed.
- Full: no push even when a pop occurs the same cycle. Empty: no pop; push and no-fire only.
- Push+pop same cycle: count unchanged, both pointers advance.
- Forward bundle:
  - On fire, the cycle after fire has fwd_* = popped entry and fwd_updated_mem_o = 1.
  - On any enabled cycle without fire, fwd_updated_mem_o = 0 and fwd_* fields hold.
- Next-memory bundle:
  - On clk_en & nm_upd_i, the next cycle has fwd_next_mem_adr_o/valid_o = inputs and fwd_next_mem_updated_o = 1.
  - Otherwise updated = 0 and fields hold.
- clk_en low: pointers, count, entries and all fwd_* registers (including updated flags) hold; mem_we_o = 0.
- Reset, including mid-drain or mid-burst:
  - count and pointers = 0; all fwd_* = 0, both updated flags = 0.
  - upd_ready_o = 1 the cycle after reset; mem_we_o = 0.
  - Buffered updates are discarded.
- Latency: empty buffer with mem_ready_i=1 → accept at cycle N, write fires N+1, fwd_updated_mem_o=1 at N+2.

Test Plan:
- Single update adr=2 key=1 data=0xA, mem_ready_i=1 → mem_we_o at cycle 1 with adr 2; cycle 2 fwd_updated_mem_o=1, fwd_data_o=0xA; cycle 3 updated=0, fwd_data_o still 0xA.
- mem_ready_i=0, push 4 updates to adrs 0,1,2,3 → upd_ready_o=0 after 4th; then mem_ready_i=1 → writes in order 0,1,2,3 and ready reasserts after first fire.
- mem_ready_i=0, push adr 1 data 3 then adr 1 data 5 → count=1; on release a single write adr 1 data 5.
- count=1 holding adr 2, fire and accept adr 2 the same cycle → push, not coalesce; two writes observed.
- nm_upd_i with adr 3, valid 0 together with a fire of adr 1 → next cycle both updated flags=1, fwd_next_mem_adr_o=3.
- Reset asserted with 3 entries buffered → next cycle count=0, mem_we_o=0, all fwd outputs 0; clk_en low for 2 cycles during drain → no write, all state held.
